// File: rtl/div_pkg.sv
// Shared definitions for the iterative arithmetic blocks: FSM state encoding and
// a constant-evaluable ceiling log2 used to size bit counters.
package div_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } div_state_e;

  // Bits needed to count 0..value-1; callers guarantee value >= 2.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned res;
    int unsigned v;
    res = 0;
    v   = value - 1;
    while (v > 0) begin
      res = res + 1;
      v   = v >> 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/seq_divider_if.sv
// Start/done handshake and operand/result bus of the sequential divider.
interface seq_divider_if #(
  parameter int unsigned N_WIDTH = 8,
  parameter int unsigned D_WIDTH = 4
) ();

  logic               start;
  logic [N_WIDTH-1:0] numerator;
  logic [D_WIDTH-1:0] denominator;
  logic               busy;
  logic               done;
  logic [N_WIDTH-1:0] quotient;
  logic [D_WIDTH-1:0] remain;
  logic               div_zero;

  modport master (
    output start, numerator, denominator,
    input  busy, done, quotient, remain, div_zero
  );

  modport slave (
    input  start, numerator, denominator,
    output busy, done, quotient, remain, div_zero
  );

endinterface

// File: rtl/div_step.sv
// One restoring-division step: trial-subtract the divisor from the shifted
// partial remainder and keep the difference only when it does not go negative.
module div_step #(
  parameter int unsigned D_WIDTH = 4
) (
  input  logic [D_WIDTH:0]   cmp_i,
  input  logic [D_WIDTH-1:0] den_i,
  output logic               q_bit_o,
  output logic [D_WIDTH-1:0] rem_o
);

  logic [D_WIDTH:0] sub;

  // The kept value is always below den_i, so its top bit is zero and is dropped.
  always_comb begin
    sub     = cmp_i - {1'b0, den_i};
    q_bit_o = ~sub[D_WIDTH];
    rem_o   = q_bit_o ? sub[D_WIDTH-1:0] : cmp_i[D_WIDTH-1:0];
  end

endmodule

// File: rtl/seq_divider.sv
// Sequential restoring divider, one quotient bit per clock, MSB first.
// Define SEQ_DIVIDER_SIGNED_EN for two's-complement operands and results.
module seq_divider
  import div_pkg::*;
#(
  parameter int unsigned N_WIDTH = 8,
  parameter int unsigned D_WIDTH = 4
) (
  input logic          clk,
  input logic          rst,
  seq_divider_if.slave bus
);

  localparam int unsigned CntW = clog2(N_WIDTH);

  div_state_e         state_q, state_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  // Dividend bits leave at the MSB while quotient bits enter at the LSB.
  logic [N_WIDTH-1:0] num_q, num_d;
  logic [D_WIDTH-1:0] den_q, den_d;
  logic [D_WIDTH-1:0] rem_q, rem_d;
  logic [N_WIDTH-1:0] quot_q, quot_d;
  logic [D_WIDTH-1:0] remo_q, remo_d;
  logic               dz_q, dz_d;

  logic [N_WIDTH-1:0] num_mag;
  logic [D_WIDTH-1:0] den_mag;
  logic [N_WIDTH-1:0] quot_raw, quot_fix;
  logic [D_WIDTH-1:0] rem_fix;
  logic               q_bit;
  logic [D_WIDTH-1:0] step_rem;
  logic               accept;

  assign accept   = (state_q == StIdle) && bus.start;
  assign quot_raw = {num_q[N_WIDTH-2:0], q_bit};

  div_step #(
    .D_WIDTH(D_WIDTH)
  ) u_step (
    .cmp_i  ({rem_q, num_q[N_WIDTH-1]}),
    .den_i  (den_q),
    .q_bit_o(q_bit),
    .rem_o  (step_rem)
  );

`ifdef SEQ_DIVIDER_SIGNED_EN
  logic num_neg_q, num_neg_d;
  logic q_neg_q, q_neg_d;

  // Divide magnitudes; -2^(N-1) maps onto itself, which reads correctly unsigned.
  always_comb begin
    num_neg_d = num_neg_q;
    q_neg_d   = q_neg_q;
    num_mag   = bus.numerator[N_WIDTH-1] ? (~bus.numerator + N_WIDTH'(1)) : bus.numerator;
    den_mag   = bus.denominator[D_WIDTH-1] ? (~bus.denominator + D_WIDTH'(1))
                                           : bus.denominator;
    if (accept) begin
      num_neg_d = bus.numerator[N_WIDTH-1];
      q_neg_d   = bus.numerator[N_WIDTH-1] ^ bus.denominator[D_WIDTH-1];
    end
    quot_fix = q_neg_q ? (~quot_raw + N_WIDTH'(1)) : quot_raw;
    rem_fix  = num_neg_q ? (~step_rem + D_WIDTH'(1)) : step_rem;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      num_neg_q <= 1'b0;
      q_neg_q   <= 1'b0;
    end else begin
      num_neg_q <= num_neg_d;
      q_neg_q   <= q_neg_d;
    end
  end
`else
  always_comb begin
    num_mag  = bus.numerator;
    den_mag  = bus.denominator;
    quot_fix = quot_raw;
    rem_fix  = step_rem;
  end
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    num_d   = num_q;
    den_d   = den_q;
    rem_d   = rem_q;
    quot_d  = quot_q;
    remo_d  = remo_q;
    dz_d    = dz_q;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          num_d = num_mag;
          den_d = den_mag;
          cnt_d = CntW'(N_WIDTH - 1);
          rem_d = '0;
          if (bus.denominator == '0) begin
            state_d = StDone;
            quot_d  = '1;
            remo_d  = '0;
            dz_d    = 1'b1;
          end else begin
            state_d = StRun;
          end
        end
      end
      StRun: begin
        num_d = quot_raw;
        rem_d = step_rem;
        cnt_d = cnt_q - CntW'(1);
        if (cnt_q == '0) begin
          state_d = StDone;
          quot_d  = quot_fix;
          remo_d  = rem_fix;
          dz_d    = 1'b0;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      num_q   <= '0;
      den_q   <= '0;
      rem_q   <= '0;
      quot_q  <= '0;
      remo_q  <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      num_q   <= num_d;
      den_q   <= den_d;
      rem_q   <= rem_d;
      quot_q  <= quot_d;
      remo_q  <= remo_d;
      dz_q    <= dz_d;
    end
  end

  assign bus.busy     = (state_q != StIdle);
  assign bus.done     = (state_q == StDone);
  assign bus.quotient = quot_q;
  assign bus.remain   = remo_q;
  assign bus.div_zero = dz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Bench for seq_divider (N_WIDTH=8, D_WIDTH=4): vector table, handshake corner
// sequences and random operands against an arithmetic reference model.
module tb_seq_divider;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  seq_divider_if #(.N_WIDTH(8), .D_WIDTH(4)) bus ();

  seq_divider #(
    .N_WIDTH(8),
    .D_WIDTH(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic [7:0] num;
    logic [3:0] den;
    logic [7:0] q;
    logic [3:0] r;
    logic       dz;
  } vec_t;

  vec_t vecs[8];
  int   n_chk  = 0;
  int   n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Reference: plain integer division, C-style truncation in signed mode.
  function automatic void model(input logic [7:0] n, input logic [3:0] d,
                                output logic [7:0] q, output logic [3:0] r,
                                output logic dz);
    int sn, sd;
    sn = 0;
    sd = 0;
    if (d == 4'd0) begin
      q  = 8'hFF;
      r  = 4'd0;
      dz = 1'b1;
    end else begin
`ifdef SEQ_DIVIDER_SIGNED_EN
      sn = $signed(n);
      sd = $signed(d);
`else
      sn = int'(n);
      sd = int'(d);
`endif
      q  = 8'(sn / sd);
      r  = 4'(sn % sd);
      dz = 1'b0;
    end
  endfunction

  // Called at a negedge in IDLE; returns at the negedge of the following IDLE cycle.
  task automatic do_op(input logic [7:0] n, input logic [3:0] d,
                       output logic [7:0] q, output logic [3:0] r, output logic dz,
                       output int lat, output int bcnt, output logic [7:0] q_hold);
    bus.start       = 1'b1;
    bus.numerator   = n;
    bus.denominator = d;
    bcnt            = 0;
    @(negedge clk);
    bus.start       = 1'b0;
    bus.numerator   = 8'($urandom);
    bus.denominator = 4'($urandom);
    for (lat = 1; lat <= 40; lat++) begin
      if (bus.busy) bcnt++;
      if (bus.done) break;
      @(negedge clk);
    end
    q  = bus.quotient;
    r  = bus.remain;
    dz = bus.div_zero;
    @(negedge clk);
    q_hold = bus.quotient;
  endtask

  initial begin
    logic [7:0] q, qh, eq;
    logic [3:0] r, er;
    logic       dz, edz;
    int         lat, bcnt;

`ifdef SEQ_DIVIDER_SIGNED_EN
    vecs[0] = '{8'h9C, 4'd7, 8'hF2, 4'hE, 1'b0};  // -100/7
    vecs[1] = '{8'h80, 4'hF, 8'h80, 4'h0, 1'b0};  // -128/-1 wraps
    vecs[2] = '{8'd5,  4'd0, 8'hFF, 4'h0, 1'b1};
    vecs[3] = '{8'd100, 4'h9, 8'hF2, 4'd2, 1'b0}; // 100/-7
    vecs[4] = '{8'hF9, 4'd2, 8'hFD, 4'hF, 1'b0};  // -7/2
    vecs[5] = '{8'd127, 4'h8, 8'hF1, 4'd7, 1'b0}; // 127/-8
    vecs[6] = '{8'd7,  4'd3, 8'd2,  4'd1, 1'b0};
    vecs[7] = '{8'hFF, 4'd3, 8'd0,  4'hF, 1'b0};  // -1/3
`else
    vecs[0] = '{8'd100, 4'd7,  8'd14,  4'd2, 1'b0};
    vecs[1] = '{8'd255, 4'd1,  8'd255, 4'd0, 1'b0};
    vecs[2] = '{8'd0,   4'd15, 8'd0,   4'd0, 1'b0};
    vecs[3] = '{8'd5,   4'd0,  8'hFF,  4'd0, 1'b1};
    vecs[4] = '{8'd15,  4'd15, 8'd1,   4'd0, 1'b0};
    vecs[5] = '{8'd200, 4'd13, 8'd15,  4'd5, 1'b0};
    vecs[6] = '{8'd7,   4'd8,  8'd0,   4'd7, 1'b0};
    vecs[7] = '{8'd255, 4'd15, 8'd17,  4'd0, 1'b0};
`endif

    rst             = 1'b1;
    bus.start       = 1'b0;
    bus.numerator   = '0;
    bus.denominator = '0;
    repeat (2) @(negedge clk);
    chk("reset busy", 32'(bus.busy), 32'd0);
    chk("reset done", 32'(bus.done), 32'd0);
    chk("reset quotient", 32'(bus.quotient), 32'd0);
    chk("reset remain", 32'(bus.remain), 32'd0);
    chk("reset div_zero", 32'(bus.div_zero), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      do_op(vecs[i].num, vecs[i].den, q, r, dz, lat, bcnt, qh);
      chk($sformatf("vec%0d quotient", i), 32'(q), 32'(vecs[i].q));
      chk($sformatf("vec%0d remain", i), 32'(r), 32'(vecs[i].r));
      chk($sformatf("vec%0d div_zero", i), 32'(dz), 32'(vecs[i].dz));
      chk($sformatf("vec%0d latency", i), 32'(lat), vecs[i].dz ? 32'd1 : 32'd9);
      chk($sformatf("vec%0d busy cycles", i), 32'(bcnt), vecs[i].dz ? 32'd1 : 32'd9);
      chk($sformatf("vec%0d quotient hold", i), 32'(qh), 32'(vecs[i].q));
      chk($sformatf("vec%0d idle done", i), 32'(bus.done), 32'd0);
    end

    // Start pulse during RUN is ignored.
    bus.start       = 1'b1;
    bus.numerator   = 8'd100;
    bus.denominator = 4'd7;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    bus.start       = 1'b1;
    bus.numerator   = 8'd9;
    bus.denominator = 4'd3;
    @(negedge clk);
    bus.start = 1'b0;
    for (lat = 4; lat <= 40; lat++) begin
      if (bus.done) break;
      @(negedge clk);
    end
    chk("run-start latency", 32'(lat), 32'd9);
    chk("run-start quotient", 32'(bus.quotient), 32'd14);
    chk("run-start remain", 32'(bus.remain), 32'd2);

    // Start held through DONE is ignored there and accepted in the next IDLE cycle.
    bus.start       = 1'b1;
    bus.numerator   = 8'd9;
    bus.denominator = 4'd3;
    @(negedge clk);
    chk("post-done idle busy", 32'(bus.busy), 32'd0);
    do_op(8'd9, 4'd3, q, r, dz, lat, bcnt, qh);
    chk("b2b quotient", 32'(q), 32'd3);
    chk("b2b remain", 32'(r), 32'd0);
    chk("b2b latency", 32'(lat), 32'd9);

    // Reset in RUN cycle 4 clears everything immediately.
    do_op(8'd203, 4'd15, q, r, dz, lat, bcnt, qh);
    model(8'd203, 4'd15, eq, er, edz);
    chk("pre-reset quotient", 32'(q), 32'(eq));
    bus.start       = 1'b1;
    bus.numerator   = 8'd100;
    bus.denominator = 4'd7;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    chk("run before reset busy", 32'(bus.busy), 32'd1);
    rst = 1'b1;
    #1;
    chk("mid-run reset busy", 32'(bus.busy), 32'd0);
    chk("mid-run reset done", 32'(bus.done), 32'd0);
    chk("mid-run reset quotient", 32'(bus.quotient), 32'd0);
    chk("mid-run reset remain", 32'(bus.remain), 32'd0);
    chk("mid-run reset div_zero", 32'(bus.div_zero), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    do_op(8'd50, 4'd6, q, r, dz, lat, bcnt, qh);
    chk("after-reset quotient", 32'(q), 32'd8);
    chk("after-reset remain", 32'(r), 32'd2);
    chk("after-reset latency", 32'(lat), 32'd9);

    for (int i = 0; i < 150; i++) begin
      logic [7:0] n;
      logic [3:0] d;
      n = 8'($urandom);
      d = ($urandom_range(0, 7) == 0) ? 4'd0 : 4'($urandom);
      model(n, d, eq, er, edz);
      do_op(n, d, q, r, dz, lat, bcnt, qh);
      chk($sformatf("rand %0h/%0h quotient", n, d), 32'(q), 32'(eq));
      chk($sformatf("rand %0h/%0h remain", n, d), 32'(r), 32'(er));
      chk($sformatf("rand %0h/%0h div_zero", n, d), 32'(dz), 32'(edz));
      chk($sformatf("rand %0h/%0h latency", n, d), 32'(lat), edz ? 32'd1 : 32'd9);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
